// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: address split, AXI burst attributes, miss FSM states.
package cc_pkg;

    localparam int unsigned LINE_OFFSET_W = 6;
    localparam int unsigned INDEX_W       = 9;
    localparam int unsigned TAG_W         = 17;

    localparam logic [3:0] AXI_LEN_LINE   = 4'd7;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } miss_state_t;

endpackage

// File: rtl/cc_outstanding_counter.sv
// Saturating up/down counter of in-flight refill bursts with a sticky underflow flag.
module cc_outstanding_counter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            err   <= 1'b0;
        end else if (inc && !dec) begin
            if (count < MAX_CNT) begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc) begin
            // rlast with nothing in flight: hold at zero and flag the protocol error
            if (count != '0) begin
                count <= count - 1'b1;
            end else begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cc_miss_req_scheduler.sv
// Accepts cache misses, pushes the line address to the miss FIFO and issues one AXI line-refill burst each.
module cc_miss_req_scheduler
    import cc_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_req_valid_i,
    input  logic [31:0]      miss_req_addr_i,
    output logic             miss_req_ready_o,
    input  logic             miss_addr_fifo_full_i,
    output logic             miss_addr_fifo_wren_o,
    output logic [31:0]      miss_addr_fifo_wdata_o,
    output logic             mem_arvalid_o,
    input  logic             mem_arready_i,
    output logic [31:0]      mem_araddr_o,
    output logic [3:0]       mem_arlen_o,
    output logic [2:0]       mem_arsize_o,
    output logic [1:0]       mem_arburst_o,
    input  logic             mem_rvalid_i,
    input  logic             mem_rlast_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    miss_state_t state, state_nxt;
    logic [31:0] line_addr;
    logic [31:0] araddr_q;
    logic        accept;
    logic        ar_hs;
    logic        r_done;
    logic        unused_offset;

    assign line_addr     = {miss_req_addr_i[31:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    assign unused_offset = ^miss_req_addr_i[LINE_OFFSET_W-1:0];

    assign miss_req_ready_o = (state == S_IDLE) && !miss_addr_fifo_full_i
                              && (outstanding_o < MAX_CNT);
    assign accept           = miss_req_valid_i && miss_req_ready_o;

    assign miss_addr_fifo_wren_o  = accept;
    assign miss_addr_fifo_wdata_o = line_addr;

    // arvalid is exactly "in ISSUE", so it resets to 0 and stays up until the handshake
    assign mem_arvalid_o = (state == S_ISSUE);
    assign mem_araddr_o  = araddr_q;
    assign mem_arlen_o   = AXI_LEN_LINE;
    assign mem_arsize_o  = AXI_SIZE_8B;
    assign mem_arburst_o = AXI_BURST_INCR;

    assign ar_hs  = mem_arvalid_o && mem_arready_i;
    assign r_done = mem_rvalid_i && mem_rlast_i;

    assign busy_o = (state == S_ISSUE) || (outstanding_o != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: if (ar_hs)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q <= '0;
        end else if (accept) begin
            araddr_q <= line_addr;
        end
    end

    cc_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_outstanding (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ar_hs),
        .dec   (r_done),
        .count (outstanding_o),
        .err   (err_o)
    );

endmodule

// File: tb/tb_cc_miss_req_scheduler.sv
// Directed bench for cc_miss_req_scheduler with hand-computed expectations.
module tb_cc_miss_req_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req_valid_i;
    logic [31:0] miss_req_addr_i;
    logic        miss_req_ready_o;
    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_rvalid_i;
    logic        mem_rlast_i;
    logic [2:0]  outstanding_o;
    logic        busy_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cc_miss_req_scheduler #(
        .MAX_OUTSTANDING (4),
        .CNT_W           (3)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_req_valid_i       (miss_req_valid_i),
        .miss_req_addr_i        (miss_req_addr_i),
        .miss_req_ready_o       (miss_req_ready_o),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_arready_i          (mem_arready_i),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rlast_i            (mem_rlast_i),
        .outstanding_o          (outstanding_o),
        .busy_o                 (busy_o),
        .err_o                  (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // accept one miss and complete its AR handshake (arready assumed high)
    task automatic issue_miss(input logic [31:0] addr);
        miss_req_valid_i = 1'b1;
        miss_req_addr_i  = addr;
        step();
        miss_req_valid_i = 1'b0;
        step();
    endtask

    task automatic rlast_pulse();
        mem_rvalid_i = 1'b1;
        mem_rlast_i  = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
    endtask

    initial begin
        rst_n                 = 1'b0;
        miss_req_valid_i      = 1'b0;
        miss_req_addr_i       = '0;
        miss_addr_fifo_full_i = 1'b0;
        mem_arready_i         = 1'b1;
        mem_rvalid_i          = 1'b0;
        mem_rlast_i           = 1'b0;
        settle();

        // reset state
        check("rst_arvalid", {31'b0, mem_arvalid_o}, 32'd0);
        check("rst_araddr", mem_araddr_o, 32'h0);
        check("rst_outstanding", {29'b0, outstanding_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_ready", {31'b0, miss_req_ready_o}, 32'd1);
        step();
        step();
        rst_n = 1'b1;

        // single miss, arready high
        miss_req_valid_i = 1'b1;
        miss_req_addr_i  = 32'h1234_5678;
        settle();
        check("t1_wren", {31'b0, miss_addr_fifo_wren_o}, 32'd1);
        check("t1_wdata", miss_addr_fifo_wdata_o, 32'h1234_5640);
        step();
        miss_req_valid_i = 1'b0;
        settle();
        check("t1_arvalid", {31'b0, mem_arvalid_o}, 32'd1);
        check("t1_araddr", mem_araddr_o, 32'h1234_5640);
        check("t1_arlen", {28'b0, mem_arlen_o}, 32'd7);
        check("t1_arsize", {29'b0, mem_arsize_o}, 32'd3);
        check("t1_arburst", {30'b0, mem_arburst_o}, 32'd1);
        check("t1_ready_issue", {31'b0, miss_req_ready_o}, 32'd0);
        check("t1_busy_issue", {31'b0, busy_o}, 32'd1);
        step();
        check("t1_outstanding", {29'b0, outstanding_o}, 32'd1);
        check("t1_arvalid_done", {31'b0, mem_arvalid_o}, 32'd0);
        check("t1_busy_out", {31'b0, busy_o}, 32'd1);
        rlast_pulse();
        settle();
        check("t1_out_after_r", {29'b0, outstanding_o}, 32'd0);
        check("t1_busy_after_r", {31'b0, busy_o}, 32'd0);

        // arready held low for 5 cycles
        mem_arready_i    = 1'b0;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i  = 32'h0000_107F;
        step();
        miss_req_addr_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("t2_arvalid_%0d", i), {31'b0, mem_arvalid_o}, 32'd1);
            check($sformatf("t2_araddr_%0d", i), mem_araddr_o, 32'h0000_1040);
            check($sformatf("t2_ready_%0d", i), {31'b0, miss_req_ready_o}, 32'd0);
            check($sformatf("t2_wren_%0d", i), {31'b0, miss_addr_fifo_wren_o}, 32'd0);
            step();
        end
        miss_req_valid_i = 1'b0;
        mem_arready_i    = 1'b1;
        settle();
        check("t2_arvalid_6", {31'b0, mem_arvalid_o}, 32'd1);
        check("t2_araddr_6", mem_araddr_o, 32'h0000_1040);
        step();
        check("t2_outstanding", {29'b0, outstanding_o}, 32'd1);
        rlast_pulse();

        // outstanding limit: four ARs issue, fifth stalls until an rlast
        for (int k = 0; k < 4; k++) begin
            issue_miss(32'h1000_0000 + 32'(k) * 32'h40);
        end
        check("t3_out_full", {29'b0, outstanding_o}, 32'd4);
        miss_req_valid_i = 1'b1;
        miss_req_addr_i  = 32'h2000_0011;
        settle();
        check("t3_ready_limit", {31'b0, miss_req_ready_o}, 32'd0);
        check("t3_wren_limit", {31'b0, miss_addr_fifo_wren_o}, 32'd0);
        step();
        check("t3_no_ar", {31'b0, mem_arvalid_o}, 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rlast_i  = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
        settle();
        check("t3_out_after_r", {29'b0, outstanding_o}, 32'd3);
        check("t3_ready_again", {31'b0, miss_req_ready_o}, 32'd1);
        check("t3_wren_fifth", {31'b0, miss_addr_fifo_wren_o}, 32'd1);
        check("t3_wdata_fifth", miss_addr_fifo_wdata_o, 32'h2000_0000);
        step();
        miss_req_valid_i = 1'b0;
        step();
        check("t3_out_refill", {29'b0, outstanding_o}, 32'd4);
        for (int k = 0; k < 4; k++) rlast_pulse();
        check("t3_out_drained", {29'b0, outstanding_o}, 32'd0);

        // FIFO full in IDLE
        miss_addr_fifo_full_i = 1'b1;
        miss_req_valid_i      = 1'b1;
        miss_req_addr_i       = 32'hABCD_EF80;
        settle();
        check("t4_ready_full", {31'b0, miss_req_ready_o}, 32'd0);
        check("t4_wren_full", {31'b0, miss_addr_fifo_wren_o}, 32'd0);
        step();
        check("t4_no_ar", {31'b0, mem_arvalid_o}, 32'd0);
        miss_addr_fifo_full_i = 1'b0;
        settle();
        check("t4_wren_release", {31'b0, miss_addr_fifo_wren_o}, 32'd1);
        check("t4_wdata_release", miss_addr_fifo_wdata_o, 32'hABCD_EF80);
        step();
        miss_req_valid_i = 1'b0;
        settle();
        check("t4_araddr", mem_araddr_o, 32'hABCD_EF80);
        step();
        rlast_pulse();

        // AR handshake coinciding with rlast at outstanding 2
        issue_miss(32'h0000_0100);
        issue_miss(32'h0000_0200);
        miss_req_valid_i = 1'b1;
        miss_req_addr_i  = 32'h0000_0300;
        step();
        miss_req_valid_i = 1'b0;
        mem_rvalid_i     = 1'b1;
        mem_rlast_i      = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
        check("t5_out_inc_dec", {29'b0, outstanding_o}, 32'd2);
        rlast_pulse();
        rlast_pulse();
        check("t5_err_before", {31'b0, err_o}, 32'd0);
        rlast_pulse();
        check("t5_err_set", {31'b0, err_o}, 32'd1);
        check("t5_out_zero", {29'b0, outstanding_o}, 32'd0);
        step();
        check("t5_err_sticky", {31'b0, err_o}, 32'd1);

        // asynchronous reset while in ISSUE with three bursts in flight
        issue_miss(32'h0000_1000);
        issue_miss(32'h0000_2000);
        issue_miss(32'h0000_3000);
        mem_arready_i    = 1'b0;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i  = 32'h0000_4000;
        step();
        miss_req_valid_i = 1'b0;
        settle();
        check("t6_arvalid_pre", {31'b0, mem_arvalid_o}, 32'd1);
        check("t6_out_pre", {29'b0, outstanding_o}, 32'd3);
        rst_n = 1'b0;
        settle();
        check("t6_arvalid_rst", {31'b0, mem_arvalid_o}, 32'd0);
        check("t6_out_rst", {29'b0, outstanding_o}, 32'd0);
        check("t6_araddr_rst", mem_araddr_o, 32'h0);
        check("t6_err_rst", {31'b0, err_o}, 32'd0);
        check("t6_ready_rst", {31'b0, miss_req_ready_o}, 32'd1);
        check("t6_busy_rst", {31'b0, busy_o}, 32'd0);
        step();
        rst_n = 1'b1;
        mem_arready_i = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
